// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-port arbiter and sequencer for a shared byte-addressed memory
module mem_port_arbiter #(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_req,
    input  logic [1:0]              m0_we,
    input  logic [2:0]              m0_readmode,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [BYTE_SIZE*8-1:0]  m0_wd,
    output logic                    m0_ack,
    output logic                    m0_err,
    output logic [BYTE_SIZE*8-1:0]  m0_rd,
    input  logic                    m1_req,
    input  logic [1:0]              m1_we,
    input  logic [2:0]              m1_readmode,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [BYTE_SIZE*8-1:0]  m1_wd,
    output logic                    m1_ack,
    output logic                    m1_err,
    output logic [BYTE_SIZE*8-1:0]  m1_rd,
    output logic [1:0]              mem_we,
    output logic [2:0]              mem_readmode,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [BYTE_SIZE*8-1:0]  mem_wd,
    input  logic [BYTE_SIZE*8-1:0]  mem_rd,
    output logic [1:0]              grant,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    state_t state_q, state_d;
    logic owner_q, owner_d, last_q, last_d;
    logic ack0_q, ack0_d, ack1_q, ack1_d, err0_q, err0_d, err1_q, err1_d, busy_q, busy_d;
    logic [1:0] grant_q, grant_d;
    logic [BYTE_SIZE*8-1:0] rd0_q, rd0_d, rd1_q, rd1_d, cap;
    logic [1:0] sel_we;
    logic [2:0] sel_rm;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BYTE_SIZE*8-1:0] sel_wd;
    logic [3:0] sz;
    logic [ADDR_WIDTH:0] end_addr;
    logic oor, in_access;
    assign sel_we   = owner_q ? m1_we : m0_we;
    assign sel_rm   = owner_q ? m1_readmode : m0_readmode;
    assign sel_addr = owner_q ? m1_addr : m0_addr;
    assign sel_wd   = owner_q ? m1_wd : m0_wd;
    assign sz = sel_we == 2'b01 ? 4'(BYTE_SIZE) : sel_we == 2'b10 ? 4'(BYTE_SIZE / 2) :
                sel_we == 2'b11 ? 4'd1 : sel_rm == 3'b000 ? 4'(BYTE_SIZE) :
                (sel_rm == 3'b001 || sel_rm == 3'b011) ? 4'(BYTE_SIZE / 2) : 4'd1;
    // one extra bit so addr + size near the top of the address space cannot wrap
    assign end_addr  = {1'b0, sel_addr} + {{(ADDR_WIDTH - 3){1'b0}}, sz};
    assign oor       = end_addr > (ADDR_WIDTH + 1)'(MEM_BYTES);
    assign in_access = state_q == ACCESS;
    assign cap       = oor ? '0 : mem_rd;
    assign mem_we       = (in_access && !oor && !rst) ? sel_we : 2'b00;
    assign mem_readmode = in_access ? sel_rm : 3'b111;
    assign mem_addr     = in_access ? sel_addr : '0;
    assign mem_wd       = in_access ? sel_wd : '0;
    assign m0_ack = ack0_q;
    assign m1_ack = ack1_q;
    assign m0_err = err0_q;
    assign m1_err = err1_q;
    assign m0_rd  = rd0_q;
    assign m1_rd  = rd1_q;
    assign grant  = grant_q;
    assign busy   = busy_q;
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err0_d  = 1'b0;
        err1_d  = 1'b0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        case (state_q)
            IDLE: if (m0_req || m1_req) begin
                owner_d = (m0_req && m1_req) ? ~last_q : m1_req;
                state_d = ACCESS;
            end
            ACCESS: begin
                ack0_d  = ~owner_q;
                ack1_d  = owner_q;
                err0_d  = ~owner_q & oor;
                err1_d  = owner_q & oor;
                rd0_d   = owner_q ? rd0_q : cap;
                rd1_d   = owner_q ? cap : rd1_q;
                last_d  = owner_q;
                state_d = ACK;
            end
            default: begin
                owner_d = (owner_q ? m0_req : m1_req) ? ~owner_q : owner_q;
                state_d = (owner_q ? m0_req : m1_req) ? ACCESS : IDLE;
            end
        endcase
        busy_d  = state_d != IDLE;
        grant_d = state_d == IDLE ? 2'b00 : owner_d ? 2'b10 : 2'b01;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            busy_q  <= 1'b0;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter against a little-endian 256-byte memory model
module tb_mem_port_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic m0_req = 0, m1_req = 0;
    logic [1:0] m0_we = 0, m1_we = 0;
    logic [2:0] m0_readmode = 0, m1_readmode = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wd = 0, m1_wd = 0;
    logic m0_ack, m1_ack, m0_err, m1_err, busy;
    logic [31:0] m0_rd, m1_rd, mem_addr, mem_wd, mem_rd;
    logic [1:0] mem_we, grant;
    logic [2:0] mem_readmode;
    logic [7:0] mem [0:255];
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] s0, s1, s2;
    int total = 0, passed = 0;
    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_readmode(m0_readmode), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_we(m1_we), .m1_readmode(m1_readmode), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rd(m1_rd),
        .mem_we(mem_we), .mem_readmode(mem_readmode), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .grant(grant), .busy(busy)
    );
    always #5 clk = ~clk;
    assign b0 = (mem_addr < 256) ? mem[mem_addr[7:0]] : 8'h0;
    assign b1 = ({1'b0, mem_addr} + 33'd1 < 33'd256) ? mem[8'(mem_addr + 1)] : 8'h0;
    assign b2 = ({1'b0, mem_addr} + 33'd2 < 33'd256) ? mem[8'(mem_addr + 2)] : 8'h0;
    assign b3 = ({1'b0, mem_addr} + 33'd3 < 33'd256) ? mem[8'(mem_addr + 3)] : 8'h0;
    assign mem_rd = mem_readmode == 3'b000 ? {b3, b2, b1, b0} :
                    mem_readmode == 3'b001 ? {16'h0, b1, b0} :
                    mem_readmode == 3'b011 ? {{16{b1[7]}}, b1, b0} :
                    mem_readmode == 3'b010 ? {24'h0, b0} :
                    mem_readmode == 3'b110 ? {{24{b0[7]}}, b0} : 32'h0;
    always @(posedge clk) begin
        if (mem_we != 2'b00 && mem_addr < 256) mem[mem_addr[7:0]] <= mem_wd[7:0];
        if ((mem_we == 2'b01 || mem_we == 2'b10) && mem_addr < 255) mem[8'(mem_addr + 1)] <= mem_wd[15:8];
        if (mem_we == 2'b01 && mem_addr < 253) begin
            mem[8'(mem_addr + 2)] <= mem_wd[23:16];
            mem[8'(mem_addr + 3)] <= mem_wd[31:24];
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic p0(input logic req, input logic [1:0] we, input logic [2:0] rm, input logic [31:0] a, input logic [31:0] wd);
        m0_req = req; m0_we = we; m0_readmode = rm; m0_addr = a; m0_wd = wd;
    endtask
    task automatic p1(input logic req, input logic [1:0] we, input logic [2:0] rm, input logic [31:0] a, input logic [31:0] wd);
        m1_req = req; m1_we = we; m1_readmode = rm; m1_addr = a; m1_wd = wd;
    endtask
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        tick(); tick();
        check("rst_acks", {30'h0, m1_ack, m0_ack}, 32'h0);
        check("rst_grant", {30'h0, grant}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_mem_we", {30'h0, mem_we}, 32'h0);
        check("rst_readmode", {29'h0, mem_readmode}, 32'h7);
        check("rst_rd0", m0_rd, 32'h0);
        check("rst_rd1", m1_rd, 32'h0);
        rst = 0;
        tick();
        p0(1, 2'b01, 3'b000, 32'h10, 32'hDEADBEEF);
        tick();
        check("wr_access_we", {30'h0, mem_we}, 32'h1);
        check("wr_access_addr", mem_addr, 32'h10);
        check("wr_access_wd", mem_wd, 32'hDEADBEEF);
        check("wr_access_grant", {30'h0, grant}, 32'h1);
        check("wr_access_noack", {31'h0, m0_ack}, 32'h0);
        tick();
        check("wr_ack", {30'h0, m0_err, m0_ack}, 32'h1);
        check("wr_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);
        check("wr_ack_we_idle", {30'h0, mem_we}, 32'h0);
        p0(0, 2'b00, 3'b000, 0, 0);
        tick();
        check("wr_idle", {30'h0, busy, m0_ack}, 32'h0);
        p0(1, 2'b00, 3'b110, 32'h13, 0);
        tick();
        check("rd_access_rm", {29'h0, mem_readmode}, 32'h6);
        tick();
        check("rd_ack", {31'h0, m0_ack}, 32'h1);
        check("rd_bytesigned", m0_rd, 32'hFFFFFFDE);
        p0(0, 2'b00, 3'b000, 0, 0);
        tick();
        check("rd_held", m0_rd, 32'hFFFFFFDE);
        rst = 1;
        tick();
        rst = 0;
        p0(1, 2'b00, 3'b000, 32'h10, 0);
        p1(1, 2'b00, 3'b011, 32'h12, 0);
        tick();
        check("tie1_grant", {30'h0, grant}, 32'h1);
        tick();
        check("tie1_ack0", {30'h0, m1_ack, m0_ack}, 32'h1);
        check("tie1_rd0", m0_rd, 32'hDEADBEEF);
        p0(0, 2'b00, 3'b000, 0, 0);
        tick();
        check("tie1_p1_access", {30'h0, grant}, 32'h2);
        check("tie1_p1_addr", mem_addr, 32'h12);
        tick();
        check("tie1_ack1", {30'h0, m1_ack, m0_ack}, 32'h2);
        check("tie1_rd1_halfsigned", m1_rd, 32'hFFFFDEAD);
        p1(0, 2'b00, 3'b000, 0, 0);
        tick();
        p0(1, 2'b00, 3'b001, 32'h10, 0);
        tick(); tick();
        check("solo_rd0_halfunsigned", m0_rd, 32'h0000BEEF);
        p0(0, 2'b00, 3'b000, 0, 0);
        tick();
        p0(1, 2'b00, 3'b010, 32'h11, 0);
        p1(1, 2'b00, 3'b000, 32'h10, 0);
        tick();
        check("tie2_grant_p1", {30'h0, grant}, 32'h2);
        tick();
        check("tie2_ack1", {30'h0, m1_ack, m0_ack}, 32'h2);
        p1(0, 2'b00, 3'b000, 0, 0);
        tick();
        check("tie2_then_p0", {30'h0, grant}, 32'h1);
        tick();
        check("tie2_ack0_byteunsigned", m0_rd, 32'h000000BE);
        p0(0, 2'b00, 3'b000, 0, 0);
        tick();
        s0 = mem[253]; s1 = mem[254]; s2 = mem[255];
        p1(1, 2'b01, 3'b000, 32'd253, 32'h12345678);
        tick();
        check("oor_we_forced", {30'h0, mem_we}, 32'h0);
        tick();
        check("oor_ack_err", {30'h0, m1_err, m1_ack}, 32'h3);
        check("oor_rd_zero", m1_rd, 32'h0);
        check("oor_mem_intact", {8'h0, mem[255], mem[254], mem[253]}, {8'h0, s2, s1, s0});
        p1(0, 2'b00, 3'b000, 0, 0);
        tick();
        p1(1, 2'b11, 3'b000, 32'd255, 32'h000000C3);
        tick();
        check("edge_byte_we", {30'h0, mem_we}, 32'h3);
        tick();
        check("edge_byte_ack", {30'h0, m1_err, m1_ack}, 32'h1);
        check("edge_byte_mem", {24'h0, mem[255]}, 32'hC3);
        p1(0, 2'b00, 3'b000, 0, 0);
        tick();
        s0 = mem[8'h20];
        p0(1, 2'b01, 3'b000, 32'h20, 32'h11223344);
        tick();
        rst = 1;
        #1;
        check("rstmid_we_forced", {30'h0, mem_we}, 32'h0);
        tick();
        check("rstmid_noack", {30'h0, busy, m0_ack}, 32'h0);
        check("rstmid_mem_intact", {24'h0, mem[8'h20]}, {24'h0, s0});
        rst = 0;
        p0(0, 2'b00, 3'b000, 0, 0);
        tick();
        p0(1, 2'b00, 3'b000, 32'h10, 0);
        tick();
        p1(1, 2'b00, 3'b010, 32'h13, 0);
        tick();
        check("starve_ack0", {30'h0, m1_ack, m0_ack}, 32'h1);
        tick();
        check("starve_p1_access", {30'h0, grant}, 32'h2);
        tick();
        check("starve_ack1", {30'h0, m1_ack, m0_ack}, 32'h2);
        check("starve_rd1", m1_rd, 32'h000000DE);
        p1(0, 2'b00, 3'b000, 0, 0);
        tick();
        check("starve_p0_resumes", {30'h0, grant}, 32'h1);
        tick();
        check("starve_ack0_again", {30'h0, m1_ack, m0_ack}, 32'h1);
        p0(0, 2'b00, 3'b000, 0, 0);
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the shared byte-addressed data memory. It sits between the CPU load/store path (port 0) and the UART receive/transmit buffer engine (port 1) on one side, and the single memory port (WE/READMODE/ADDR/WD/RD) on the other. It grants one access at a time with round-robin fairness, registers read data back to the winner, and suppresses out-of-range accesses.

## Interface
- BYTE_SIZE, 4: memory word width in bytes; data width is BYTE_SIZE*8.
- ADDR_WIDTH, 32: address width.
- MEM_BYTES, 256: memory depth in bytes, used for the range check.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mN_req  in  1  request from port N (N = 0, 1); held high until mN_ack.
- mN_we  in  2  00 read, 01 word write, 10 half write, 11 byte write.
- mN_readmode  in  3  000 word, 001 half-unsigned, 011 half-signed, 010 byte-unsigned, 110 byte-signed.
- mN_addr  in  ADDR_WIDTH  byte address.
- mN_wd  in  BYTE_SIZE*8  write data.
- mN_ack  out  1  one-cycle completion pulse.
- mN_err  out  1  valid with mN_ack; access was out of range and suppressed.
- mN_rd  out  BYTE_SIZE*8  registered read data, valid with mN_ack, held until next ack to that port.
- mem_we  out  2  to memory WE.
- mem_readmode  out  3  to memory READMODE.
- mem_addr  out  ADDR_WIDTH  to memory ADDR.
- mem_wd  out  BYTE_SIZE*8  to memory WD.
- mem_rd  in  BYTE_SIZE*8  from memory RD (combinational read).
- grant  out  2  one-hot current owner: 01 port 0, 10 port 1, 00 none.
- busy  out  1  high in ACCESS and ACK.

## Operation
- States: IDLE, ACCESS, ACK. Registers: state, owner, last (last port served), acks, errs, rd regs.
- Reset: state IDLE, last = 1 (port 0 wins the first tie), grant 00, busy 0, all acks/errs 0, both mN_rd 0.
- IDLE: if any req, pick owner -> ACCESS. When only one port requests, that port wins. When both request, the port != last wins.
- ACCESS (one cycle): memory signals driven combinationally from the owner's inputs. At the edge, a write commits; mem_rd is captured into the owner's rd; last <= owner -> ACK.
- ACK: the owner's ack is 1 and its req is ignored this cycle. If the other port's req is high, it becomes owner -> ACCESS directly. Otherwise -> IDLE.
- Idle drive, outside ACCESS: mem_we 00, mem_readmode 111, mem_addr 0, mem_wd 0.
- Access size: from we if nonzero (01 = 4, 10 = 2, 11 = 1). Otherwise from readmode (000 = 4, 001/011 = 2, 010/110 = 1, others = 1).
- Range check: if addr + size > MEM_BYTES, the access is out of range. Use a compare wide enough that it cannot wrap.
- Out-of-range access: in ACCESS, mem_we is forced to 00, the captured rd is 0, and err is 1 with ack.
- mem_we is forced to 00 whenever rst = 1, so no write commits on a reset edge.

## Timing
- Latency: req sampled high in IDLE at cycle T -> ACCESS at T+1 -> ack at T+2.
- Read data is visible on mN_rd in the ack cycle.
- Throughput: with alternating contention, one access every 2 cycles. A single port gets one access per 3 cycles (IDLE, ACCESS, ACK).
- Requesters hold we/readmode/addr/wd stable from req rise through ack.
- Reset mid-ACCESS: no write commits, no ack is issued, and the state goes to IDLE.
- Reset during ACK: the ack drops on the next cycle.
- A req that falls before ack (protocol violation) still completes using the values present in ACCESS.

## Test plan
- Reset: hold rst 2 cycles -> all acks 0, grant 00, busy 0, mem_we 00, mem_readmode 111, rd 0.
- Single write/read: port 0 word-writes 0xDEADBEEF to addr 0x10, then byte-signed reads 0x13 -> mem_we 01 in ACCESS, ack 2 cycles after req, m0_rd = 0xFFFFFFDE.
- Contention: both ports request simultaneously from reset -> port 0 served first, port 1 ACCESS in the cycle right after port 0's ack. A repeated tie is then won by port 1.
- Range: port 1 word write at addr 253 (MEM_BYTES 256) -> mem_we stays 00, m1_ack with m1_err = 1, memory bytes 253..255 unchanged. Byte write at 255 -> succeeds, err 0.
- Reset mid-access: assert rst during port 0's ACCESS cycle of a write to 0x20 -> byte 0x20 unchanged, no m0_ack, IDLE next cycle.
- Starvation: port 0 requests continuously, port 1 raises req once -> port 1 acked within 4 cycles and port 0 continues afterwards.
